// File: rtl/pixel_word_packer_pkg.sv
// ----------------------------------------------------------------------------
// pixel_word_packer_pkg
// Shared sizing constants, FSM state encodings and byte-enable helpers for the
// pixel word packer and its word slots.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package pixel_word_packer_pkg;

  localparam int MEM_WORD_BITS   = 32;
  localparam int PIXEL_BITS      = 8;
  localparam int PIXELS_PER_WORD = MEM_WORD_BITS / PIXEL_BITS;
  localparam int IDX_BITS        = $clog2(PIXELS_PER_WORD);
  localparam int COUNT_BITS      = 16;

  // Byte-enable patterns for a word holding 1..4 pixels, MSB-first.
  localparam logic [PIXELS_PER_WORD-1:0] BE_1 = 4'b1000;
  localparam logic [PIXELS_PER_WORD-1:0] BE_2 = 4'b1100;
  localparam logic [PIXELS_PER_WORD-1:0] BE_3 = 4'b1110;
  localparam logic [PIXELS_PER_WORD-1:0] BE_4 = 4'b1111;

  typedef enum logic {
    FILL_A = 1'b0,
    FILL_B = 1'b1
  } fill_state_e;

  typedef enum logic {
    DRAIN_A = 1'b0,
    DRAIN_B = 1'b1
  } drain_state_e;

  // Single byte-enable bit for pixel position idx (position 0 is the MSB lane).
  function automatic logic [PIXELS_PER_WORD-1:0] lane_be(input logic [IDX_BITS-1:0] idx);
    lane_be = BE_1 >> idx;
  endfunction

endpackage

// File: rtl/pixel_word_packer_if.sv
// ----------------------------------------------------------------------------
// pixel_word_packer_if
// Pixel-side handshake and memory write port of the packer.
//   pixel/pixel_valid/pixel_ready/flush : filter -> packer stream
//   mem_data/mem_byte_en/mem_write_req/mem_write_ack : packer -> memory port
// slave  : packer view.   master : filter/memory-controller (testbench) view.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface pixel_word_packer_if;
  import pixel_word_packer_pkg::*;

  logic [PIXEL_BITS-1:0]      pixel;
  logic                       pixel_valid;
  logic                       pixel_ready;
  logic                       flush;
  logic [MEM_WORD_BITS-1:0]   mem_data;
  logic [PIXELS_PER_WORD-1:0] mem_byte_en;
  logic                       mem_write_req;
  logic                       mem_write_ack;

  modport slave (
    input  pixel, pixel_valid, flush, mem_write_ack,
    output pixel_ready, mem_data, mem_byte_en, mem_write_req
  );

  modport master (
    output pixel, pixel_valid, flush, mem_write_ack,
    input  pixel_ready, mem_data, mem_byte_en, mem_write_req
  );

endinterface

// File: rtl/pixel_word_slot.sv
// ----------------------------------------------------------------------------
// pixel_word_slot
// One memory-word buffer: data word, byte-enable mask and full flag.
//   clk, reset    : clock, async active-low reset
//   load          : write byte_data into lane byte_idx (MSB-first) and set its enable
//   close         : mark the word full (complete or flushed)
//   clear         : empty the slot (word accepted by memory); wins over load/close
//   word/byte_en/full : slot contents
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module pixel_word_slot
  import pixel_word_packer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [IDX_BITS-1:0]        byte_idx,
  input  logic [PIXEL_BITS-1:0]      byte_data,
  input  logic                       close,
  input  logic                       clear,
  output logic [MEM_WORD_BITS-1:0]   word,
  output logic [PIXELS_PER_WORD-1:0] byte_en,
  output logic                       full
);

  logic [MEM_WORD_BITS-1:0]   word_r;
  logic [PIXELS_PER_WORD-1:0] byte_en_r;
  logic                       full_r;

  // Slot storage: clear empties it, otherwise pixels land lane by lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_r    <= '0;
      byte_en_r <= '0;
      full_r    <= 1'b0;
    end else if (clear) begin
      word_r    <= '0;
      byte_en_r <= '0;
      full_r    <= 1'b0;
    end else begin
      for (int k = 0; k < PIXELS_PER_WORD; k++) begin
        if (load && (byte_idx == IDX_BITS'(k))) begin
          word_r[MEM_WORD_BITS-1-PIXEL_BITS*k -: PIXEL_BITS] <= byte_data;
        end
      end
      if (load) begin
        byte_en_r <= byte_en_r | lane_be(byte_idx);
      end
      if (close) begin
        full_r <= 1'b1;
      end
    end
  end

  assign word    = word_r;
  assign byte_en = byte_en_r;
  assign full    = full_r;

endmodule

// File: rtl/pixel_word_packer.sv
// ----------------------------------------------------------------------------
// pixel_word_packer
// Packs pixels MSB-first into 32-bit memory words using a ping-pong pair of
// word slots, so the filter keeps streaming while a finished word waits for
// memory acceptance.
//   clk, reset    : clock, async active-low reset
//   bus (slave)   : pixel stream in, memory write port out
//   words_written : words accepted by memory, wraps at 16 bits
//   idle          : both slots empty and no partial pixels held
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module pixel_word_packer
  import pixel_word_packer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  pixel_word_packer_if.slave      bus,
  output logic [COUNT_BITS-1:0]   words_written,
  output logic                    idle
);

  fill_state_e              fill_state_r,  fill_state_n_s;
  drain_state_e             drain_state_r, drain_state_n_s;
  logic [IDX_BITS-1:0]      idx_r,         idx_n_s;
  logic [COUNT_BITS-1:0]    words_written_r, words_written_n_s;

  logic [MEM_WORD_BITS-1:0]   word_a_s,  word_b_s;
  logic [PIXELS_PER_WORD-1:0] be_a_s,    be_b_s;
  logic                       full_a_s,  full_b_s;

  logic fill_full_s, xfer_s, close_s, fill_is_a_s;
  logic req_s, ack_xfer_s, drain_is_a_s;

  // Fill-side handshake: a slot is writable until it is marked full.
  always_comb begin
    fill_is_a_s = 1'b1;
    case (fill_state_r)
      FILL_A:  fill_is_a_s = 1'b1;
      FILL_B:  fill_is_a_s = 1'b0;
      default: fill_is_a_s = 1'b1;
    endcase
    fill_full_s = fill_is_a_s ? full_a_s : full_b_s;
    xfer_s      = bus.pixel_valid && !fill_full_s;
    // A flush only closes a word that actually holds pixels (incl. this cycle's).
    // When the fill slot is full no pixel can be held in it, so flush is ignored.
    close_s     = (xfer_s && (idx_r == IDX_BITS'(PIXELS_PER_WORD-1))) ||
                  (bus.flush && !fill_full_s && ((idx_r != '0) || xfer_s));
  end

  // Fill FSM next state and byte index.
  always_comb begin
    fill_state_n_s = fill_state_r;
    idx_n_s        = idx_r;
    if (close_s) begin
      idx_n_s = '0;
      case (fill_state_r)
        FILL_A:  fill_state_n_s = FILL_B;
        FILL_B:  fill_state_n_s = FILL_A;
        default: fill_state_n_s = FILL_A;
      endcase
    end else if (xfer_s) begin
      idx_n_s = idx_r + IDX_BITS'(1);
    end else begin
      idx_n_s = idx_r;
    end
  end

  // Drain-side handshake: request whenever the drain slot holds a full word.
  always_comb begin
    drain_is_a_s = 1'b1;
    case (drain_state_r)
      DRAIN_A: drain_is_a_s = 1'b1;
      DRAIN_B: drain_is_a_s = 1'b0;
      default: drain_is_a_s = 1'b1;
    endcase
    req_s      = drain_is_a_s ? full_a_s : full_b_s;
    ack_xfer_s = req_s && bus.mem_write_ack;
  end

  // Drain FSM next state and accepted-word counter.
  always_comb begin
    drain_state_n_s   = drain_state_r;
    words_written_n_s = words_written_r;
    if (ack_xfer_s) begin
      words_written_n_s = words_written_r + COUNT_BITS'(1);
      case (drain_state_r)
        DRAIN_A: drain_state_n_s = DRAIN_B;
        DRAIN_B: drain_state_n_s = DRAIN_A;
        default: drain_state_n_s = DRAIN_A;
      endcase
    end else begin
      drain_state_n_s   = drain_state_r;
      words_written_n_s = words_written_r;
    end
  end

  // State registers for both FSMs, pixel index and counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_state_r    <= FILL_A;
      drain_state_r   <= DRAIN_A;
      idx_r           <= '0;
      words_written_r <= '0;
    end else begin
      fill_state_r    <= fill_state_n_s;
      drain_state_r   <= drain_state_n_s;
      idx_r           <= idx_n_s;
      words_written_r <= words_written_n_s;
    end
  end

  pixel_word_slot u_slot_a (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer_s && fill_is_a_s),
    .byte_idx  (idx_r),
    .byte_data (bus.pixel),
    .close     (close_s && fill_is_a_s),
    .clear     (ack_xfer_s && drain_is_a_s),
    .word      (word_a_s),
    .byte_en   (be_a_s),
    .full      (full_a_s)
  );

  pixel_word_slot u_slot_b (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer_s && !fill_is_a_s),
    .byte_idx  (idx_r),
    .byte_data (bus.pixel),
    .close     (close_s && !fill_is_a_s),
    .clear     (ack_xfer_s && !drain_is_a_s),
    .word      (word_b_s),
    .byte_en   (be_b_s),
    .full      (full_b_s)
  );

  // Memory port outputs: the drain slot may be partly filled while not full,
  // so data and enables are gated by the request.
  always_comb begin
    bus.mem_write_req = req_s;
    if (req_s) begin
      bus.mem_data    = drain_is_a_s ? word_a_s : word_b_s;
      bus.mem_byte_en = drain_is_a_s ? be_a_s   : be_b_s;
    end else begin
      bus.mem_data    = '0;
      bus.mem_byte_en = '0;
    end
  end

  assign bus.pixel_ready = !fill_full_s;
  assign words_written   = words_written_r;
  assign idle            = !full_a_s && !full_b_s && (idx_r == '0);

endmodule

// File: tb/tb_pixel_word_packer.sv
`timescale 1ns/1ps
module tb_pixel_word_packer;
  import pixel_word_packer_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] words_written;
  logic        idle;
  int          n_cmp;
  int          n_err;
  int          stalls;

  pixel_word_packer_if bus ();

  pixel_word_packer dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .words_written (words_written),
    .idle          (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] p);
    bus.pixel       = p;
    bus.pixel_valid = 1'b1;
    tick();
    bus.pixel_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    stalls = 0;
    reset = 1'b0;
    bus.pixel = 8'h00;
    bus.pixel_valid = 1'b0;
    bus.flush = 1'b0;
    bus.mem_write_ack = 1'b0;
    #12;
    chk("rst_ready", 32'(bus.pixel_ready), 32'd1);
    chk("rst_req",   32'(bus.mem_write_req), 32'd0);
    chk("rst_data",  bus.mem_data, 32'h0);
    chk("rst_be",    32'(bus.mem_byte_en), 32'h0);
    chk("rst_count", 32'(words_written), 32'd0);
    chk("rst_idle",  32'(idle), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Four pixels back-to-back with ack held high.
    bus.mem_write_ack = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    chk("t1_req",  32'(bus.mem_write_req), 32'd1);
    chk("t1_data", bus.mem_data, 32'h11223344);
    chk("t1_be",   32'(bus.mem_byte_en), 32'(BE_4));
    tick();
    chk("t1_count", 32'(words_written), 32'd1);
    chk("t1_req_low", 32'(bus.mem_write_req), 32'd0);
    chk("t1_idle", 32'(idle), 32'd1);

    // Eight pixels with no ack: both slots fill, stream stalls.
    bus.mem_write_ack = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("t2_ready", 32'(bus.pixel_ready), 32'd0);
    chk("t2_dataA", bus.mem_data, 32'h01020304);
    chk("t2_beA",   32'(bus.mem_byte_en), 32'hF);
    push(8'h99);  // must be refused
    bus.mem_write_ack = 1'b1;
    tick();
    bus.mem_write_ack = 1'b0;
    chk("t2_dataB",  bus.mem_data, 32'h05060708);
    chk("t2_ready2", 32'(bus.pixel_ready), 32'd1);
    chk("t2_count1", 32'(words_written), 32'd2);
    bus.mem_write_ack = 1'b1;
    tick();
    bus.mem_write_ack = 1'b0;
    chk("t2_count2", 32'(words_written), 32'd3);
    chk("t2_idle",   32'(idle), 32'd1);

    // Partial word closed by flush.
    push(8'hAA); push(8'hBB);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t3_req",  32'(bus.mem_write_req), 32'd1);
    chk("t3_data", bus.mem_data, 32'hAABB0000);
    chk("t3_be",   32'(bus.mem_byte_en), 32'(BE_2));
    bus.mem_write_ack = 1'b1;
    tick();
    bus.mem_write_ack = 1'b0;
    chk("t3_count", 32'(words_written), 32'd4);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t3_empty_flush_req", 32'(bus.mem_write_req), 32'd0);
    chk("t3_empty_flush_idle", 32'(idle), 32'd1);

    // Flush in the same cycle as the third pixel.
    push(8'h5A); push(8'h6B);
    bus.flush = 1'b1;
    push(8'hCC);
    bus.flush = 1'b0;
    chk("t4_data", bus.mem_data, 32'h5A6BCC00);
    chk("t4_be",   32'(bus.mem_byte_en), 32'(BE_3));
    bus.mem_write_ack = 1'b1;
    tick();
    bus.mem_write_ack = 1'b0;
    chk("t4_count", 32'(words_written), 32'd5);

    // Asynchronous reset with two pixels held.
    push(8'h12); push(8'h34);
    chk("t5_busy", 32'(idle), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_req",   32'(bus.mem_write_req), 32'd0);
    chk("t5_idle",  32'(idle), 32'd1);
    chk("t5_count", 32'(words_written), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("t5_no_req", 32'(bus.mem_write_req), 32'd0);
    push(8'h9A); push(8'hBC); push(8'hDE); push(8'hF0);
    chk("t5_data", bus.mem_data, 32'h9ABCDEF0);
    chk("t5_be",   32'(bus.mem_byte_en), 32'hF);
    bus.mem_write_ack = 1'b1;
    tick();
    chk("t5_count1", 32'(words_written), 32'd1);

    // Stream one-pixel flushed words at full rate up to 0xFFFF, then wrap.
    bus.flush = 1'b1;
    bus.pixel_valid = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      bus.pixel = 8'(i);
      if (!bus.pixel_ready) stalls++;
      tick();
    end
    bus.pixel_valid = 1'b0;
    bus.flush = 1'b0;
    for (int k = 0; k < 8 && !idle; k++) tick();
    chk("t6_no_stall", 32'(stalls), 32'd0);
    chk("t6_drained",  32'(idle), 32'd1);
    chk("t6_count_max", 32'(words_written), 32'h0000FFFF);
    bus.flush = 1'b1;
    push(8'h77);
    bus.flush = 1'b0;
    chk("t6_last_data", bus.mem_data, 32'h77000000);
    tick();
    chk("t6_wrap", 32'(words_written), 32'd0);
    bus.mem_write_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
